// File: rtl/sin_cos_dco_multi.sv
// Time-multiplexed multi-channel sine/cosine DCO: one channel per CE slot, each
// with its own phase accumulator, slewed increment and clear request, sharing one sine ROM.

module sin_cos_dco_lane #(
  parameter int PB         = 32,
  parameter int PIB        = 28,
  parameter int AW         = 12,
  parameter int SLEW_SHIFT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           slot,
  input  logic           we,
  input  logic [PIB-1:0] target_in,
  input  logic           clear_req,
  output logic [AW-1:0]  addr
);
  logic [PB-1:0]  phase, p;
  logic [PIB-1:0] target, cur_inc, next_inc;
  logic           clr_pend;

  // The sample reflects the phase before this slot's accumulate.
  assign p    = clr_pend ? '0 : phase;
  assign addr = p[PB-1 -: AW];

  if (SLEW_SHIFT == 0) begin : g_imm
    assign next_inc = target;
  end else begin : g_slew
    logic signed [PIB:0] d, step;
    always_comb begin
      d    = $signed({1'b0, target}) - $signed({1'b0, cur_inc});
      step = d >>> SLEW_SHIFT;
      // A tiny residual difference still has to close, one LSB per slot.
      if (step == '0 && d != '0)
        step = d[PIB] ? '1 : {{PIB{1'b0}}, 1'b1};
    end
    assign next_inc = cur_inc + step[PIB-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      target   <= '0;
      cur_inc  <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (slot) begin
        phase   <= p + {{(PB-PIB){1'b0}}, cur_inc};
        cur_inc <= next_inc;
      end
      if (we) target <= target_in;
      // A fresh request beats the consume on the same edge.
      if (clear_req)  clr_pend <= 1'b1;
      else if (slot)  clr_pend <= 1'b0;
    end
  end
endmodule

module sin_cos_dco_multi #(
  parameter int CHANNELS             = 4,
  parameter int PHASE_BITS           = 32,
  parameter int PHASE_INCREMENT_BITS = 28,
  parameter int SIN_TABLE_DATA_WIDTH = 13,
  parameter int SIN_TABLE_ADDR_WIDTH = 12,
  parameter int SLEW_SHIFT           = 0,
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   CE,
  input  logic [PHASE_INCREMENT_BITS-1:0]        PHASE_INCREMENT_IN,
  input  logic [CH_BITS-1:0]                     PHASE_INCREMENT_CH,
  input  logic                                   PHASE_INCREMENT_IN_WE,
  input  logic [CHANNELS-1:0]                    PHASE_CLEAR_IN,
  output logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
  output logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
  output logic [CH_BITS-1:0]                     OUT_CHANNEL,
  output logic                                   OUT_VALID
);
  localparam int SDW = SIN_TABLE_DATA_WIDTH;
  localparam int AW  = SIN_TABLE_ADDR_WIDTH;

  function automatic logic signed [SDW-1:0] rom_val(input int k);
    real x;
    int  r;
    x = real'((2 ** (SDW - 1)) - 1) * $sin(2.0 * 3.141592653589793 * real'(k) / real'(2 ** AW));
    r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return SDW'(r);
  endfunction

  logic signed [SDW-1:0] rom [2**AW];
  for (genvar k = 0; k < 2**AW; k++) begin : g_rom
    assign rom[k] = rom_val(k);
  end

  logic [CH_BITS-1:0]             ch;
  logic [CHANNELS-1:0][AW-1:0]    lane_addr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    sin_cos_dco_lane #(
      .PB(PHASE_BITS), .PIB(PHASE_INCREMENT_BITS), .AW(AW), .SLEW_SHIFT(SLEW_SHIFT)
    ) u_lane (
      .clk      (CLK),
      .rst      (RESET),
      .slot     (CE && (ch == CH_BITS'(i))),
      .we       (PHASE_INCREMENT_IN_WE && (PHASE_INCREMENT_CH == CH_BITS'(i))),
      .target_in(PHASE_INCREMENT_IN),
      .clear_req(PHASE_CLEAR_IN[i]),
      .addr     (lane_addr[i])
    );
  end

  logic [AW-1:0]         addr_s, addr_c, s1_addr_s, s1_addr_c;
  logic [CH_BITS-1:0]    s1_ch, s2_ch;
  logic signed [SDW-1:0] s2_sin, s2_cos;
  logic [2:1]            vld_pipe;

  // Cosine is the sine a quarter wave ahead.
  assign addr_s = lane_addr[ch];
  assign addr_c = addr_s + {2'b01, {(AW-2){1'b0}}};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ch          <= '0;
      s1_addr_s   <= '0;
      s1_addr_c   <= '0;
      s1_ch       <= '0;
      s2_sin      <= '0;
      s2_cos      <= '0;
      s2_ch       <= '0;
      vld_pipe    <= '0;
      SIN_VALUE   <= '0;
      COS_VALUE   <= '0;
      OUT_CHANNEL <= '0;
      OUT_VALID   <= 1'b0;
    end else if (CE) begin
      ch          <= (ch == CH_BITS'(CHANNELS - 1)) ? '0 : ch + 1'b1;
      s1_addr_s   <= addr_s;
      s1_addr_c   <= addr_c;
      s1_ch       <= ch;
      s2_sin      <= rom[s1_addr_s];
      s2_cos      <= rom[s1_addr_c];
      s2_ch       <= s1_ch;
      vld_pipe    <= {vld_pipe[1], 1'b1};
      SIN_VALUE   <= s2_sin;
      COS_VALUE   <= s2_cos;
      OUT_CHANNEL <= s2_ch;
      OUT_VALID   <= vld_pipe[2];
    end else begin
      OUT_VALID   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sin_cos_dco_multi.sv
// Directed bench for sin_cos_dco_multi: a per-slot scoreboard against a hand-computed
// quarter-wave sine table, plus a slewed instance for the increment glide.

module tb_sin_cos_dco_multi;
  logic               CLK, RESET, CE, WE;
  logic [27:0]        INC;
  logic [1:0]         INC_CH;
  logic [3:0]         CLR;
  logic signed [12:0] sin_v, cos_v, sin_s, cos_s;
  logic [1:0]         och, och_s;
  logic               ovld, ovld_s;

  sin_cos_dco_multi u_dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .PHASE_INCREMENT_IN(INC), .PHASE_INCREMENT_CH(INC_CH), .PHASE_INCREMENT_IN_WE(WE),
    .PHASE_CLEAR_IN(CLR),
    .SIN_VALUE(sin_v), .COS_VALUE(cos_v), .OUT_CHANNEL(och), .OUT_VALID(ovld)
  );

  sin_cos_dco_multi #(.SLEW_SHIFT(2)) u_slew (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .PHASE_INCREMENT_IN(INC), .PHASE_INCREMENT_CH(INC_CH), .PHASE_INCREMENT_IN_WE(WE),
    .PHASE_CLEAR_IN(CLR),
    .SIN_VALUE(sin_s), .COS_VALUE(cos_s), .OUT_CHANNEL(och_s), .OUT_VALID(ovld_s)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // round(4095*sin(2*pi*k/64)), k = 0..16
  int qtab[17] = '{0, 401, 799, 1189, 1567, 1930, 2275, 2598, 2896,
                   3165, 3405, 3611, 3783, 3919, 4016, 4075, 4095};

  function automatic int tsin(input logic [11:0] a);
    int j;
    if (a[5:0] != 6'd0) return 99999;
    j = int'(a[11:6]);
    if (j <= 16) return qtab[j];
    if (j <= 32) return qtab[32 - j];
    if (j <= 48) return -qtab[j - 32];
    return -qtab[64 - j];
  endfunction

  typedef struct { int ch; logic [11:0] addr; } smp_t;
  smp_t        q[$];
  logic [31:0] ph [4];
  logic [27:0] cur [4], tgt [4];
  logic [3:0]  pend;
  int          slot_ch, last_slot_ch;
  int          e_sin, e_cos, e_ch;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin ph[i] = '0; cur[i] = '0; tgt[i] = '0; end
    pend = '0; slot_ch = 0; q.delete();
    e_sin = 0; e_cos = 0; e_ch = 0;
  endtask

  task automatic tick();
    smp_t s; logic [31:0] p; logic ce_e; int c;
    @(posedge CLK);
    ce_e = CE;
    if (ce_e) begin
      c = slot_ch;
      p = pend[c] ? 32'd0 : ph[c];
      ph[c] = p + {4'b0, cur[c]};
      cur[c] = tgt[c];
      pend[c] = 1'b0;
      s.ch = c; s.addr = p[31:20];
      q.push_back(s);
      last_slot_ch = c;
      slot_ch = (c + 1) % 4;
    end else last_slot_ch = -1;
    pend |= CLR;
    if (WE) tgt[INC_CH] = INC;
    #1;
    if (ce_e && q.size() > 2) begin
      s = q.pop_front();
      e_sin = tsin(s.addr); e_cos = tsin(s.addr + 12'd1024); e_ch = s.ch;
      chk("valid", ovld, 1);
      chk("sin", sin_v, e_sin);
      chk("cos", cos_v, e_cos);
      chk("chan", och, e_ch);
    end else begin
      chk("valid_low", ovld, 0);
      chk("hold_sin", sin_v, e_sin);
      chk("hold_cos", cos_v, e_cos);
      chk("hold_chan", och, e_ch);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    chk("rst_valid", ovld, 0);
    chk("rst_sin", sin_v, 0);
    chk("rst_cos", cos_v, 0);
    chk("rst_chan", och, 0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wr(input logic [1:0] c, input logic [27:0] v);
    INC_CH = c; INC = v; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic run_basic(input int n);
    CE = 1'b0;
    wr(2'd0, 28'h800_0000);
    wr(2'd1, 28'h400_0000);
    CE = 1'b1;
    repeat (n) tick();
  endtask

  int sl_exp[4] = '{256, 448, 592, 700};
  int k;

  initial begin
    CLK = 1'b0; CE = 1'b0; WE = 1'b0; INC = '0; INC_CH = '0; CLR = '0;
    last_slot_ch = -1;
    do_reset();

    // two running channels, two idle channels
    run_basic(4 * 70);

    // clear ch0 away from its slot, then on its own slot edge
    while (slot_ch != 1) tick();
    CLR = 4'b0001; tick(); CLR = '0;
    repeat (12) tick();
    while (slot_ch != 0) tick();
    CLR = 4'b0001; tick(); CLR = '0;
    repeat (16) tick();

    // stalls must neither drop nor repeat samples
    repeat (300) begin
      CE = 1'($urandom_range(0, 1));
      tick();
    end
    CE = 1'b1;
    repeat (8) tick();

    // asynchronous reset between edges, then restart
    #2;
    do_reset();
    run_basic(4 * 20);

    // slewed increment glide on ch0
    #2;
    do_reset();
    CE = 1'b0;
    wr(2'd0, 28'd1024);
    CE = 1'b1;
    k = 0;
    repeat (4 * 45) begin
      tick();
      if (last_slot_ch == 0) begin
        if (k < 4) chk("slew_step", u_slew.g_lane[0].u_lane.cur_inc, sl_exp[k]);
        k++;
      end
    end
    chk("slew_final", u_slew.g_lane[0].u_lane.cur_inc, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
